direct_mapped_wb_cache: RTL

//  Parametrised direct-mapped, write-back, write-allocate cache; one data word per line.

---
 rtl/direct_mapped_wb_cache_pkg.sv | 20 ++
 rtl/cache_line_store.sv | 53 +++++
 rtl/direct_mapped_wb_cache.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/direct_mapped_wb_cache_pkg.sv
// rtl/direct_mapped_wb_cache_pkg.sv - shared FSM states and helpers for the direct-mapped cache
package direct_mapped_wb_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WBACK   = 3'd2,
        ST_REFILL  = 3'd3,
        ST_RESPOND = 3'd4,
        ST_FLUSH   = 3'd5
    } state_t;

    localparam int StatsWidth = 32;

    // Saturating increment used by the optional hit/miss counters
    function automatic logic [StatsWidth-1:0] sat_inc(input logic [StatsWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - valid/dirty/tag/data line arrays with one write port and indexed read
module cache_line_store #(
    parameter int DataWidth  = 8,
    parameter int TagWidth   = 10,
    parameter int IndexWidth = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IndexWidth-1:0] idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TagWidth-1:0]   rd_tag,
    output logic [DataWidth-1:0]  rd_data,
    input  logic                  we_valid,
    input  logic                  we_dirty,
    input  logic                  we_tag,
    input  logic                  we_data,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TagWidth-1:0]   wr_tag,
    input  logic [DataWidth-1:0]  wr_data
);

    localparam int Lines = 1 << IndexWidth;

    logic [Lines-1:0]     valid_q;
    logic [Lines-1:0]     dirty_q;
    logic [TagWidth-1:0]  tag_q  [Lines];
    logic [DataWidth-1:0] data_q [Lines];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    // State bits: cleared on reset, otherwise per-field write of the addressed line
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (we_valid) valid_q[idx] <= wr_valid;
            if (we_dirty) dirty_q[idx] <= wr_dirty;
        end
    end

    // Payload fields: meaningless while the line is invalid, so no reset needed
    always_ff @(posedge clk) begin
        if (we_tag)  tag_q[idx]  <= wr_tag;
        if (we_data) data_q[idx] <= wr_data;
    end

endmodule

// File: rtl/direct_mapped_wb_cache.sv
// rtl/direct_mapped_wb_cache.sv - direct-mapped write-back cache top; CACHE_STATS_EN adds hit/miss counters
module direct_mapped_wb_cache
    import direct_mapped_wb_cache_pkg::*;
#(
    parameter int DataWidth  = 8,
    parameter int AddrWidth  = 16,
    parameter int IndexWidth = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [AddrWidth-1:0] cpu_addr,
    input  logic [DataWidth-1:0] cpu_wdata,
    output logic [DataWidth-1:0] cpu_rdata,
    output logic                 cpu_ready,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata,
    input  logic                 mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [StatsWidth-1:0] hit_count,
    output logic [StatsWidth-1:0] miss_count
`endif
);

    localparam int TagWidth = AddrWidth - IndexWidth;

    state_t                state;
    logic [AddrWidth-1:0]  req_addr;
    logic                  req_we;
    logic [DataWidth-1:0]  req_wdata;
    logic [IndexWidth-1:0] fcnt;

    logic [TagWidth-1:0]   req_tag;
    logic [IndexWidth-1:0] req_idx;
    logic [IndexWidth-1:0] line_idx;
    logic                  rd_valid, rd_dirty;
    logic [TagWidth-1:0]   rd_tag;
    logic [DataWidth-1:0]  rd_data;
    logic                  we_valid, we_dirty, we_tag, we_data;
    logic                  wr_valid, wr_dirty;
    logic [TagWidth-1:0]   wr_tag;
    logic [DataWidth-1:0]  wr_data;
    logic                  hit;
    logic                  flush_step;

    assign req_tag = req_addr[AddrWidth-1:IndexWidth];
    assign req_idx = req_addr[IndexWidth-1:0];

    cache_line_store #(
        .DataWidth (DataWidth),
        .TagWidth  (TagWidth),
        .IndexWidth(IndexWidth)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .idx     (line_idx),
        .rd_valid(rd_valid),
        .rd_dirty(rd_dirty),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .we_valid(we_valid),
        .we_dirty(we_dirty),
        .we_tag  (we_tag),
        .we_data (we_data),
        .wr_valid(wr_valid),
        .wr_dirty(wr_dirty),
        .wr_tag  (wr_tag),
        .wr_data (wr_data)
    );

    // Line selection, hit detection and line-store updates for the current state
    always_comb begin
        line_idx   = (state == ST_FLUSH) ? fcnt : req_idx;
        hit        = rd_valid && (rd_tag == req_tag);
        // In flush a line is finished when clean, or when its writeback is acknowledged
        flush_step = mem_req ? mem_ack : !(rd_valid && rd_dirty);
        we_valid   = 1'b0;
        we_dirty   = 1'b0;
        we_tag     = 1'b0;
        we_data    = 1'b0;
        wr_valid   = 1'b0;
        wr_dirty   = 1'b0;
        wr_tag     = req_tag;
        wr_data    = req_wdata;
        case (state)
            ST_LOOKUP: begin
                if (hit && req_we) begin
                    we_data  = 1'b1;
                    we_dirty = 1'b1;
                    wr_dirty = 1'b1;
                end
            end
            ST_WBACK: begin
                if (mem_req && mem_ack) begin
                    we_dirty = 1'b1;
                end
            end
            ST_REFILL: begin
                if (mem_req && mem_ack) begin
                    we_valid = 1'b1;
                    we_dirty = 1'b1;
                    we_tag   = 1'b1;
                    we_data  = 1'b1;
                    wr_valid = 1'b1;
                    wr_data  = mem_rdata;
                end
            end
            ST_RESPOND: begin
                if (req_we) begin
                    we_valid = 1'b1;
                    we_dirty = 1'b1;
                    we_tag   = 1'b1;
                    we_data  = 1'b1;
                    wr_valid = 1'b1;
                    wr_dirty = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_step) begin
                    we_valid = 1'b1;
                    we_dirty = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Main FSM: request latch, memory handshake, flush walk, registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            fcnt       <= '0;
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            flush_done <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            cpu_ready  <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        fcnt  <= '0;
                        state <= ST_FLUSH;
                    end else if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        cpu_ready <= 1'b1;
                        if (!req_we) cpu_rdata <= rd_data;
                        state <= ST_IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        state <= ST_WBACK;
                    end else begin
                        state <= req_we ? ST_RESPOND : ST_REFILL;
                    end
                end
                // Memory states raise mem_req on entry so it is always low for a cycle between transfers
                ST_WBACK: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {rd_tag, req_idx};
                        mem_wdata <= rd_data;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= req_we ? ST_RESPOND : ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= req_addr;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    cpu_ready <= 1'b1;
                    if (!req_we) cpu_rdata <= rd_data;
                    state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (flush_step) begin
                        mem_req <= 1'b0;
                        fcnt    <= fcnt + 1'b1;
                        if (fcnt == {IndexWidth{1'b1}}) begin
                            flush_done <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {rd_tag, fcnt};
                        mem_wdata <= rd_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // One count per LOOKUP outcome, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit) hit_count  <= sat_inc(hit_count);
            else     miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule
